// File: rtl/triggered_timestamp_fifo_if.sv
// Event stream from triggered_timestamp_fifo to its consumer (register bridge or DMA feeder).
//   ev_valid : head entry present          ev_ready : consumer pops head on valid && ready
//   ev_count : head timestamp              ev_ch    : head channel index
//   ev_multi : head event saw more than one qualifying channel
interface triggered_timestamp_fifo_if #(
   parameter int unsigned COUNT_W = 32,
   parameter int unsigned CH_W    = 2
);
   logic               ev_valid;
   logic               ev_ready;
   logic [COUNT_W-1:0] ev_count;
   logic [CH_W-1:0]    ev_ch;
   logic               ev_multi;

   modport master (output ev_valid, ev_count, ev_ch, ev_multi, input  ev_ready);
   modport slave  (input  ev_valid, ev_count, ev_ch, ev_multi, output ev_ready);
endinterface

// File: rtl/triggered_timestamp_fifo.sv
// Multi-channel triggered timestamp capture.
// Asynchronous triggers are synchronised and edge-detected per channel (polarity + enable),
// gated by a programmable global cooldown, and each accepted event pushes {count, channel,
// multi} into a first-word-fall-through FIFO. The last accepted count is also held on
// count_latched.
// Ports:
//   clk, rstn          : clock, asynchronous active-low reset
//   trigger            : asynchronous trigger inputs, one per channel
//   ch_enable/edge_sel : per-channel enable; 1 = rising edge, 0 = falling edge
//   cooldown_len       : dead cycles after an accepted event (0 = none)
//   count              : free-running timestamp source
//   count_latched      : count of the most recent accepted event
//   ev                 : FIFO head, valid/ready (master modport)
//   fifo_level         : entries stored
//   overflow_cnt       : saturating count of events dropped on a full FIFO
//   clear_overflow     : synchronous clear of overflow_cnt
module triggered_timestamp_fifo #(
   parameter int unsigned N_CH        = 4,
   parameter int unsigned COUNT_W     = 32,
   parameter int unsigned COOLDOWN_W  = 18,
   parameter int unsigned DEPTH       = 16,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic                       clk,
   input  logic                       rstn,
   input  logic [N_CH-1:0]            trigger,
   input  logic [N_CH-1:0]            ch_enable,
   input  logic [N_CH-1:0]            edge_sel,
   input  logic [COOLDOWN_W-1:0]      cooldown_len,
   input  logic [COUNT_W-1:0]         count,
   output logic [COUNT_W-1:0]         count_latched,
   triggered_timestamp_fifo_if.master ev,
   output logic [$clog2(DEPTH):0]     fifo_level,
   output logic [15:0]                overflow_cnt,
   input  logic                       clear_overflow
);

   localparam int unsigned CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned LVL_W = PTR_W + 1;

   typedef struct packed {
      logic               multi;
      logic [CH_W-1:0]    ch;
      logic [COUNT_W-1:0] ts;
   } entry_t;

   (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0][N_CH-1:0] sync_q;
   logic [N_CH-1:0]       hist_q;
   logic [SYNC_STAGES:0]  prime_q;
   logic [N_CH-1:0]       qual_c;
   logic [N_CH-1:0]       qual_q;
   logic [COOLDOWN_W-1:0] cooldown_q;
   logic [CH_W-1:0]       first_ch_c;
   logic                  multi_c;
   logic                  decide_c;
   logic                  valid_c;
   logic                  full_c;
   logic                  pop_c;
   logic                  push_c;
   logic [PTR_W-1:0]      wr_ptr_q;
   logic [PTR_W-1:0]      rd_ptr_q;
   entry_t                mem_q [DEPTH];
   entry_t                head_c;
   entry_t                new_entry_c;

   // Synchroniser chain; index 0 is the first flop, SYNC_STAGES-1 feeds edge detection.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], trigger};
      end
   end

   // Edge history always follows the synchronised level, independent of enable/cooldown.
   // prime_q masks detection until the chain and history hold real samples after reset,
   // so a trigger already high at release is seen as a settled level, not an edge.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         hist_q  <= '0;
         prime_q <= '0;
         qual_q  <= '0;
      end else begin
         hist_q  <= sync_q[SYNC_STAGES-1];
         prime_q <= {prime_q[SYNC_STAGES-1:0], 1'b1};
         qual_q  <= qual_c;
      end
   end

   always_comb begin
      qual_c = '0;
      if (prime_q[SYNC_STAGES]) begin
         qual_c = ch_enable & (( edge_sel &  sync_q[SYNC_STAGES-1] & ~hist_q)
                             | (~edge_sel & ~sync_q[SYNC_STAGES-1] &  hist_q));
      end
   end

   // Lowest qualifying channel wins the entry.
   always_comb begin
      first_ch_c = '0;
      for (int i = N_CH - 1; i >= 0; i--) begin
         if (qual_q[i]) first_ch_c = CH_W'(i);
      end
   end

   // More than one bit set: clearing the lowest set bit leaves something.
   assign multi_c  = |(qual_q & (qual_q - N_CH'(1)));
   assign decide_c = (|qual_q) && (cooldown_q == '0);

   // Cooldown: length sampled only when an event is accepted.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cooldown_q <= '0;
      end else if (decide_c) begin
         cooldown_q <= cooldown_len;
      end else if (cooldown_q != '0) begin
         cooldown_q <= cooldown_q - COOLDOWN_W'(1);
      end
   end

   // FIFO control: a full FIFO still accepts when the head is popped on the same edge.
   assign valid_c = (fifo_level != '0);
   assign full_c  = (fifo_level == LVL_W'(DEPTH));
   assign pop_c   = valid_c && ev.ev_ready;
   assign push_c  = decide_c && (!full_c || pop_c);

   assign new_entry_c = '{multi: multi_c, ch: first_ch_c, ts: count};

   always_ff @(posedge clk) begin
      if (push_c) mem_q[wr_ptr_q] <= new_entry_c;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         fifo_level <= '0;
      end else begin
         if (push_c) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop_c)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         case ({push_c, pop_c})
            2'b10:   fifo_level <= fifo_level + LVL_W'(1);
            2'b01:   fifo_level <= fifo_level - LVL_W'(1);
            default: fifo_level <= fifo_level;
         endcase
      end
   end

   // count_latched follows every accepted decision, including drops on a full FIFO.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         count_latched <= '0;
      end else if (decide_c) begin
         count_latched <= count;
      end
   end

   // Drop counter; clear wins over a same-cycle drop.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         overflow_cnt <= '0;
      end else if (clear_overflow) begin
         overflow_cnt <= '0;
      end else if (decide_c && !push_c && (overflow_cnt != 16'hFFFF)) begin
         overflow_cnt <= overflow_cnt + 16'd1;
      end
   end

   // Head fields are forced to zero while empty so the array itself needs no reset.
   assign head_c      = mem_q[rd_ptr_q];
   assign ev.ev_valid = valid_c;
   assign ev.ev_count = valid_c ? head_c.ts    : '0;
   assign ev.ev_ch    = valid_c ? head_c.ch    : '0;
   assign ev.ev_multi = valid_c ? head_c.multi : 1'b0;

endmodule

// File: tb/tb_triggered_timestamp_fifo.sv
// Directed bench for triggered_timestamp_fifo: reset/idle, latency, polarity/enable,
// cooldown, overflow, drain with pointer wrap, async reset mid-fill.
module tb_triggered_timestamp_fifo;

   localparam int unsigned N_CH        = 4;
   localparam int unsigned COUNT_W     = 32;
   localparam int unsigned COOLDOWN_W  = 18;
   localparam int unsigned DEPTH       = 16;
   localparam int unsigned SYNC_STAGES = 2;
   localparam int unsigned CH_W        = 2;

   logic                  clk = 1'b0;
   logic                  rstn;
   logic [N_CH-1:0]       trigger;
   logic [N_CH-1:0]       ch_enable;
   logic [N_CH-1:0]       edge_sel;
   logic [COOLDOWN_W-1:0] cooldown_len;
   logic [COUNT_W-1:0]    count;
   logic [COUNT_W-1:0]    count_latched;
   logic [4:0]            fifo_level;
   logic [15:0]           overflow_cnt;
   logic                  clear_overflow;

   int n_tests = 0;
   int n_fail  = 0;

   logic [31:0] exp_ts [$];
   logic [1:0]  exp_ch [$];

   triggered_timestamp_fifo_if #(.COUNT_W(COUNT_W), .CH_W(CH_W)) ev_if ();

   triggered_timestamp_fifo #(
      .N_CH(N_CH), .COUNT_W(COUNT_W), .COOLDOWN_W(COOLDOWN_W),
      .DEPTH(DEPTH), .SYNC_STAGES(SYNC_STAGES)
   ) dut (
      .clk            (clk),
      .rstn           (rstn),
      .trigger        (trigger),
      .ch_enable      (ch_enable),
      .edge_sel       (edge_sel),
      .cooldown_len   (cooldown_len),
      .count          (count),
      .count_latched  (count_latched),
      .ev             (ev_if),
      .fifo_level     (fifo_level),
      .overflow_cnt   (overflow_cnt),
      .clear_overflow (clear_overflow)
   );

   always #5 clk = ~clk;

   // Free-running timestamp source.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) count <= '0;
      else       count <= count + 32'd1;
   end

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic pop_one();
      ev_if.ev_ready = 1'b1;
      @(negedge clk);
      ev_if.ev_ready = 1'b0;
   endtask

   // Rising pulse on channel c; returns the timestamp it should capture (3 edges later).
   task automatic pulse(input int c, output logic [31:0] ts);
      trigger[c] = 1'b1;
      ts = count + 32'd3;
      repeat (2) @(negedge clk);
      trigger[c] = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic drain_check(input string tag);
      ev_if.ev_ready = 1'b1;
      while (exp_ts.size() > 0) begin
         chk({tag, "_valid"}, ev_if.ev_valid, 1);
         chk({tag, "_ts"},    ev_if.ev_count, exp_ts.pop_front());
         chk({tag, "_ch"},    ev_if.ev_ch,    exp_ch.pop_front());
         @(negedge clk);
      end
      ev_if.ev_ready = 1'b0;
      chk({tag, "_empty"}, ev_if.ev_valid, 0);
      chk({tag, "_level"}, fifo_level, 0);
   endtask

   initial begin
      logic [31:0] t0;
      logic [31:0] ts;

      rstn           = 1'b0;
      trigger        = 4'b0001;
      ch_enable      = 4'hF;
      edge_sel       = 4'b1011;
      cooldown_len   = '0;
      clear_overflow = 1'b0;
      ev_if.ev_ready = 1'b0;

      // Reset and idle with trigger[0] already high.
      repeat (3) @(negedge clk);
      chk("rst_valid",   ev_if.ev_valid, 0);
      chk("rst_level",   fifo_level, 0);
      chk("rst_latched", count_latched, 0);
      rstn = 1'b1;
      repeat (8) @(negedge clk);
      chk("idle_valid", ev_if.ev_valid, 0);
      chk("idle_level", fifo_level, 0);
      chk("idle_ovf",   overflow_cnt, 0);

      // Single rising event on ch1 with count=100 at E0.
      for (int i = 0; i < 400 && count != 32'd100; i++) @(negedge clk);
      chk("sync_count", count, 100);
      trigger = 4'b0011;
      repeat (3) @(negedge clk);
      chk("lat_early", ev_if.ev_valid, 0);
      @(negedge clk);
      chk("single_valid",   ev_if.ev_valid, 1);
      chk("single_ch",      ev_if.ev_ch, 1);
      chk("single_ts",      ev_if.ev_count, 103);
      chk("single_latched", count_latched, 103);
      chk("single_multi",   ev_if.ev_multi, 0);
      chk("single_level",   fifo_level, 1);
      pop_one();
      chk("single_popped", ev_if.ev_valid, 0);

      // Polarity: ch2 is falling-edge selected.
      trigger = 4'b0111;
      repeat (6) @(negedge clk);
      chk("ch2_rise_none", fifo_level, 0);
      trigger = 4'b0011;
      t0 = count;
      repeat (4) @(negedge clk);
      chk("ch2_fall_valid", ev_if.ev_valid, 1);
      chk("ch2_fall_ch",    ev_if.ev_ch, 2);
      chk("ch2_fall_ts",    ev_if.ev_count, t0 + 32'd3);
      pop_one();
      chk("ch2_popped", fifo_level, 0);

      // Enable: disabled ch3 edges ignored; enabling on a steady high level is silent.
      ch_enable = 4'b0111;
      trigger = 4'b1011; repeat (6) @(negedge clk);
      trigger = 4'b0011; repeat (6) @(negedge clk);
      trigger = 4'b1011; repeat (6) @(negedge clk);
      chk("ch3_disabled", fifo_level, 0);
      ch_enable = 4'hF;
      repeat (6) @(negedge clk);
      chk("ch3_en_steady", fifo_level, 0);
      trigger = 4'b0000;
      repeat (6) @(negedge clk);
      chk("falls_none", fifo_level, 0);

      // Simultaneous ch0+ch3 with cooldown 5; ch1 at +3 dropped, at +6 accepted.
      cooldown_len = 18'd5;
      trigger = 4'b1001;
      t0 = count;
      repeat (3) @(negedge clk);
      trigger = 4'b1011;
      @(negedge clk);
      chk("sim_valid",   ev_if.ev_valid, 1);
      chk("sim_ch",      ev_if.ev_ch, 0);
      chk("sim_multi",   ev_if.ev_multi, 1);
      chk("sim_ts",      ev_if.ev_count, t0 + 32'd3);
      trigger = 4'b1001;
      repeat (2) @(negedge clk);
      trigger = 4'b1011;
      @(negedge clk);
      chk("cd_discard_level",   fifo_level, 1);
      chk("cd_discard_latched", count_latched, t0 + 32'd3);
      repeat (3) @(negedge clk);
      chk("cd_accept_level",   fifo_level, 2);
      chk("cd_accept_latched", count_latched, t0 + 32'd9);
      ev_if.ev_ready = 1'b1;
      @(negedge clk);
      chk("cd_head_ch",    ev_if.ev_ch, 1);
      chk("cd_head_ts",    ev_if.ev_count, t0 + 32'd9);
      chk("cd_head_multi", ev_if.ev_multi, 0);
      @(negedge clk);
      ev_if.ev_ready = 1'b0;
      chk("cd_drained", ev_if.ev_valid, 0);
      cooldown_len = '0;
      trigger = 4'b0000;
      repeat (6) @(negedge clk);

      // Overflow: 20 events into a 16-deep FIFO with no consumer.
      for (int k = 0; k < 20; k++) begin
         pulse(0, ts);
         if (exp_ts.size() < DEPTH) begin
            exp_ts.push_back(ts);
            exp_ch.push_back(2'd0);
         end
      end
      repeat (4) @(negedge clk);
      chk("ovf_level",   fifo_level, 16);
      chk("ovf_count",   overflow_cnt, 4);
      chk("ovf_latched", count_latched, ts);

      // Event on the same edge as a pop is accepted while full.
      trigger[0] = 1'b1;
      ts = count + 32'd3;
      repeat (3) @(negedge clk);
      ev_if.ev_ready = 1'b1;
      @(negedge clk);
      ev_if.ev_ready = 1'b0;
      trigger[0] = 1'b0;
      void'(exp_ts.pop_front());
      void'(exp_ch.pop_front());
      exp_ts.push_back(ts);
      exp_ch.push_back(2'd0);
      chk("pushpop_level", fifo_level, 16);
      chk("pushpop_ovf",   overflow_cnt, 4);
      clear_overflow = 1'b1;
      @(negedge clk);
      clear_overflow = 1'b0;
      chk("ovf_cleared", overflow_cnt, 0);
      @(negedge clk);

      drain_check("drain_full");

      // Fill/drain three times across the pointer wrap, alternating channels.
      for (int r = 0; r < 3; r++) begin
         for (int k = 0; k < 10; k++) begin
            pulse(k % 2, ts);
            exp_ts.push_back(ts);
            exp_ch.push_back(2'(k % 2));
         end
         repeat (2) @(negedge clk);
         chk("wrap_level", fifo_level, 10);
         drain_check("wrap");
      end

      // Asynchronous reset in the middle of a fill.
      for (int k = 0; k < 5; k++) pulse(1, ts);
      repeat (2) @(negedge clk);
      chk("mid_level", fifo_level, 5);
      #2 rstn = 1'b0;
      #1;
      chk("arst_valid",   ev_if.ev_valid, 0);
      chk("arst_level",   fifo_level, 0);
      chk("arst_latched", count_latched, 0);
      chk("arst_ts",      ev_if.ev_count, 0);
      chk("arst_ch",      ev_if.ev_ch, 0);
      chk("arst_ovf",     overflow_cnt, 0);
      @(negedge clk);
      rstn = 1'b1;
      repeat (4) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

endmodule
